// File: rtl/muldiv_sched.sv
// muldiv_sched: sequences the shared multiply/divide units and the HI/LO register writes.
// Ports: clock, reset (async, active-low); mult_req/div_req requests from control;
// mult_done/div_done/div0 from the units; mult_ctrl/div_ctrl unit starts;
// hi_ctrl/lo_ctrl HI/LO mux selects (1 = multiply); write_hi/write_lo HI/LO write enables;
// busy, and retire pulses done/div0_exc/timeout; drop flags a discarded request.
module muldiv_sched #(
   parameter int MAX_WAIT = 40
) (
   input  logic clock,
   input  logic reset,
   input  logic mult_req,
   input  logic div_req,
   input  logic mult_done,
   input  logic div_done,
   input  logic div0,
   output logic mult_ctrl,
   output logic div_ctrl,
   output logic hi_ctrl,
   output logic lo_ctrl,
   output logic write_hi,
   output logic write_lo,
   output logic busy,
   output logic done,
   output logic div0_exc,
   output logic timeout,
   output logic drop
);
   localparam int W = $clog2(MAX_WAIT);
   typedef enum logic [2:0] {IDLE, START, WAIT, WRITE, EXC, TOUT} state_t;
   state_t state, state_n;
   logic op, op_n, mult_pend, mult_pend_n, div_pend, div_pend_n, drop_n;
   logic [W-1:0] cnt, cnt_n;
   logic retire, mult_take, div_take, unit_done;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state <= IDLE;
         op <= 1'b0;
         cnt <= '0;
         mult_pend <= 1'b0;
         div_pend <= 1'b0;
         drop <= 1'b0;
      end else begin
         state <= state_n;
         op <= op_n;
         cnt <= cnt_n;
         mult_pend <= mult_pend_n;
         div_pend <= div_pend_n;
         drop <= drop_n;
      end
   // A retiring state hands off to a pending op; mult has priority over div.
   assign retire = state == WRITE || state == EXC || state == TOUT;
   assign mult_take = retire && mult_pend;
   assign div_take = retire && !mult_pend && div_pend;
   assign unit_done = op ? mult_done : div_done;
   always_comb begin
      state_n = state;
      op_n = op;
      cnt_n = cnt;
      mult_pend_n = mult_pend;
      div_pend_n = div_pend;
      drop_n = 1'b0;
      case (state)
         IDLE: begin
            state_n = mult_req || div_req ? START : IDLE;
            op_n = mult_req ? 1'b1 : div_req ? 1'b0 : op;
            div_pend_n = mult_req && div_req;
         end
         START: begin
            state_n = WAIT;
            cnt_n = '0;
         end
         WAIT: begin
            state_n = unit_done ? (!op && div0 ? EXC : WRITE) :
                      cnt == W'(MAX_WAIT - 1) ? TOUT : WAIT;
            cnt_n = unit_done || cnt == W'(MAX_WAIT - 1) ? cnt : cnt + W'(1);
         end
         default: begin
            state_n = mult_take || div_take ? START : IDLE;
            op_n = mult_take ? 1'b1 : div_take ? 1'b0 : op;
         end
      endcase
      // A re-request of a slot being consumed this cycle refills it instead of dropping.
      if (state != IDLE) begin
         mult_pend_n = mult_req || (mult_pend && !mult_take);
         div_pend_n = div_req || (div_pend && !div_take);
         drop_n = (mult_req && mult_pend && !mult_take) || (div_req && div_pend && !div_take);
      end
   end
   assign busy = state != IDLE;
   assign mult_ctrl = state == START && op;
   assign div_ctrl = state == START && !op;
   assign hi_ctrl = op;
   assign lo_ctrl = op;
   assign write_hi = state == WRITE;
   assign write_lo = state == WRITE;
   assign done = retire;
   assign div0_exc = state == EXC;
   assign timeout = state == TOUT;
endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: cycle table of inputs/expected outputs for muldiv_sched, plus reset sequences.
module tb_muldiv_sched;
   logic clock = 1'b0, reset = 1'b0;
   logic mult_req = 0, div_req = 0, mult_done = 0, div_done = 0, div0 = 0;
   logic mult_ctrl, div_ctrl, hi_ctrl, lo_ctrl, write_hi, write_lo, busy, done, div0_exc, timeout, drop;
   int total = 0, bad = 0;
   localparam logic [4:0] MR = 5'h10, DQ = 5'h08, MD = 5'h04, DD = 5'h02, Z = 5'h01, NI = 5'h00;
   localparam logic [10:0] MC = 11'h400, DC = 11'h200, HL = 11'h180, WR = 11'h060,
                           BZ = 11'h010, DN = 11'h008, EX = 11'h004, TO = 11'h002, DR = 11'h001, NO = 11'h000;
   typedef struct {
      logic [4:0] in;
      logic [10:0] exp;
   } vec_t;
   vec_t tv[$];
   logic [10:0] outs;
   assign outs = {mult_ctrl, div_ctrl, hi_ctrl, lo_ctrl, write_hi, write_lo, busy, done, div0_exc, timeout, drop};
   muldiv_sched #(.MAX_WAIT(4)) dut (
      .clock(clock), .reset(reset), .mult_req(mult_req), .div_req(div_req),
      .mult_done(mult_done), .div_done(div_done), .div0(div0),
      .mult_ctrl(mult_ctrl), .div_ctrl(div_ctrl), .hi_ctrl(hi_ctrl), .lo_ctrl(lo_ctrl),
      .write_hi(write_hi), .write_lo(write_lo), .busy(busy), .done(done),
      .div0_exc(div0_exc), .timeout(timeout), .drop(drop)
   );
   always #5 clock = ~clock;
   task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b (mc dc hi lo whi wlo busy done exc tout drop)", name, act, exp);
      end
   endtask
   task automatic add(input logic [4:0] i, input logic [10:0] e);
      tv.push_back('{i, e});
   endtask
   task automatic drive(input logic [4:0] i);
      {mult_req, div_req, mult_done, div_done, div0} = i;
   endtask
   initial begin
      add(MR, NO);                    // 0 multiply, done 2 cycles after start
      add(NI, MC|HL|BZ);
      add(NI, HL|BZ);
      add(MD, HL|BZ);
      add(NI, HL|BZ|WR|DN);
      add(NI, HL);
      add(DQ, HL);                    // 6 divide by zero
      add(NI, DC|BZ);
      add(DD|Z, BZ);
      add(NI, BZ|EX|DN);
      add(NI, NO);
      add(MR|DQ, NO);                 // 11 simultaneous requests
      add(NI, MC|HL|BZ);
      add(MD, HL|BZ);
      add(NI, HL|BZ|WR|DN);
      add(NI, DC|BZ);
      add(DD, BZ);
      add(NI, BZ|WR|DN);
      add(NI, NO);
      add(DQ, NO);                    // 19 two mult requests during a divide
      add(NI, DC|BZ);
      add(MR, BZ);
      add(NI, BZ);
      add(MR, BZ);
      add(DD, BZ|DR);
      add(NI, BZ|WR|DN);
      add(NI, MC|HL|BZ);
      add(MD, HL|BZ);
      add(NI, HL|BZ|WR|DN);
      add(NI, HL);
      add(NI, HL);
      add(MR, HL);                    // 31 timeout; div_done ignored for a multiply
      add(NI, MC|HL|BZ);
      add(NI, HL|BZ);
      add(DD, HL|BZ);
      add(NI, HL|BZ);
      add(NI, HL|BZ);
      add(NI, HL|BZ|TO|DN);
      add(NI, HL);
      add(DQ, HL);                    // 39 done in limit cycle wins
      add(NI, DC|BZ);
      add(NI, BZ);
      add(MD, BZ);
      add(NI, BZ);
      add(DD, BZ);
      add(NI, BZ|WR|DN);
      add(NI, NO);
      add(DQ, NO);                    // 47 re-request while pending slot is consumed
      add(MR, DC|BZ);
      add(DD, BZ);
      add(MR, BZ|WR|DN);
      add(NI, MC|HL|BZ);
      add(MD, HL|BZ);
      add(NI, HL|BZ|WR|DN);
      add(NI, MC|HL|BZ);
      add(MD, HL|BZ);
      add(NI, HL|BZ|WR|DN);
      add(NI, HL);
      repeat (2) @(negedge clock);
      chk("reset_state", outs, NO);
      reset = 1'b1;
      foreach (tv[i]) begin
         drive(tv[i].in);
         chk($sformatf("vec%0d", i), outs, tv[i].exp);
         @(negedge clock);
      end
      drive(MR|DQ);
      @(negedge clock);
      drive(NI);
      chk("rst_seq_start", outs, MC|HL|BZ);
      @(negedge clock);
      chk("rst_seq_wait", outs, HL|BZ);
      reset = 1'b0;
      #1;
      chk("rst_async_outs", outs, NO);
      repeat (2) @(negedge clock);
      chk("rst_held", outs, NO);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         chk($sformatf("post_rst%0d", i), outs, NO);
      end
      drive(DQ);
      @(negedge clock);
      drive(NI);
      chk("post_rst_accept", outs, DC|BZ);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
